sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter that shares the board's external 18-bit × 16-bit SRAM controller request interface (`sram_req`/`sram_ready`/… ) between the debug-bus RAM port (port 0) and the core memory port (port 1). It registers one granted command at a time toward the SRAM controller. It tracks outstanding reads in order, so returned read data is steered back to the requester that issued it.

## Interface
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 16, SRAM data width
- `RD_DEPTH`, 4, maximum outstanding reads (tag FIFO depth, power of two ≥ 2)

One clock; reset is asynchronous and active-high.

- `clk` input 1 system clock
- `rst` input 1 asynchronous active-high reset
- `pN_req` input 1 port N (N = 0, 1) command valid
- `pN_ready` output 1 port N command accepted this cycle
- `pN_rd` input 1 1 = read, 0 = write
- `pN_addr` input ADDR_W word address
- `pN_be` input 2 byte enables {UB, LB}
- `pN_wr_data` input DATA_W write data
- `pN_rd_data_vld` output 1 read data valid for port N
- `pN_rd_data` output DATA_W read data, shared copy of `sram_rd_data`
- `sram_req` output 1 command valid to SRAM controller
- `sram_ready` input 1 controller accepts command
- `sram_rd`, `sram_addr`, `sram_be`, `sram_wr_data` output 1/ADDR_W/2/DATA_W registered command fields
- `sram_rd_data_vld` input 1 controller read data valid, in issue order
- `sram_rd_data` input DATA_W controller read data
- `rd_err` output 1 sticky: `sram_rd_data_vld` arrived with no read outstanding

## Operation
- Handshake on both sides: a transfer occurs when `req && ready` are high in the same cycle. A requester holds its fields stable while `req` is high and `ready` is low. `pN_ready` is combinational from current state and inputs, and is never high for both ports in one cycle.
- One-entry command register (`cmd_vld` plus fields) drives the `sram_*` outputs. `sram_req = cmd_vld`.
- The register can load when it is empty, or when it is emptying this cycle (`cmd_vld && sram_ready`). This gives back-to-back issue at one command per cycle.
- Eligible port: `pN_req`, and either it is a write or `rd_cnt < RD_DEPTH`.
  - `rd_cnt` counts reads sitting in the command register plus reads issued but not yet returned.
- If both ports are eligible, round-robin selects the port not granted last. The `last` bit updates on every grant.
- Read issued (`cmd_vld && sram_ready && sram_rd`): push the port id into the tag FIFO.
- `sram_rd_data_vld`: pop the FIFO head and assert `p<head>_rd_data_vld` in the same cycle (combinational). `rd_data` is not registered.
- Push and pop in the same cycle are both honoured. Occupancy is unchanged.
- `sram_rd_data_vld` with an empty FIFO: no port strobe; `rd_err` sets and holds until reset.
- Writes produce no response.

## Timing
- Reset values:
  - `sram_req` 0; `sram_rd`, `sram_addr`, `sram_be`, `sram_wr_data` all 0
  - `pN_ready` 0, `pN_rd_data_vld` 0, `rd_err` 0
  - `last` = 1, so port 0 wins the first contention
  - FIFO empty, `rd_cnt` 0
- Accept-to-issue latency: port accepted in cycle n → `sram_req` high from cycle n+1.
- Read return to port: same cycle as `sram_rd_data_vld`.
- `sram_req` stays high and the fields stay stable until `sram_ready`.
- Reset mid-operation drops the command register and tags. Any in-flight return after reset hits an empty FIFO and sets `rd_err`; the controller is reset by the same `rst`.
- Read accept blocked at `rd_cnt == RD_DEPTH`. Writes are still accepted.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins when both ports are eligible, and the `last` bit is not implemented.
- Not defined: round-robin as above.

## Structure
- Shared package `sram_pkg`:
  - constants `SRAM_ADDR_W` = 18, `SRAM_DATA_W` = 16
  - typedef struct `sram_cmd_t` {rd, addr, be, wr_data}
  - typedef `sram_port_t` (1-bit port id)
- One sub-module `sram_arb_tagfifo`: RD_DEPTH × 1-bit synchronous FIFO with push, pop, empty, full and count, on the same clock and reset.

## Test plan
- Single write from p0 (addr 0x00010, be 2'b11, data 0xA5A5), `sram_ready` = 1 → p0_ready in cycle 0; `sram_req`/addr/data valid in cycle 1 only.
- Both ports request reads every cycle, `sram_ready` = 1 → grants alternate p0, p1, p0, …; tags return in the same order; each `pN_rd_data_vld` matches its issuer.
- Fixed-priority build with the same stimulus → p0 granted every cycle; p1 never granted while p0 requests.
- `sram_ready` held low 3 cycles with command pending → `sram_req` and fields stable for 3 cycles; no new `pN_ready`.
- p1 issues 4 reads with no data returned → fifth read stalls (`p1_ready` = 0); p0 write still accepted; one return → p1 read accepted next.
- `sram_rd_data_vld` pulse after reset with nothing outstanding → no port strobe; `rd_err` = 1 and holds.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the external SRAM controller request path.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Requester id: 0 = debug-bus RAM port, 1 = core memory port
  typedef logic sram_port_t;

  typedef struct packed {
    logic                   rd;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [1:0]             be;
    logic [SRAM_DATA_W-1:0] wr_data;
  } sram_cmd_t;

endpackage

// File: rtl/sram_arb_tagfifo.sv
// In-order tag FIFO: remembers which port issued each outstanding read.
module sram_arb_tagfifo
  import sram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sram_port_t    push_data,
  input  logic          pop,
  output sram_port_t    head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the external SRAM controller.
// Port 0 = debug-bus RAM port, port 1 = core memory port.
// Build option SRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention
// (no round-robin state); otherwise round-robin on the last granted port.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int RD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  output logic              p0_ready,
  input  logic              p0_rd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [1:0]        p0_be,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_rd_data_vld,
  output logic [DATA_W-1:0] p0_rd_data,

  input  logic              p1_req,
  output logic              p1_ready,
  input  logic              p1_rd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p1_be,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_rd_data_vld,
  output logic [DATA_W-1:0] p1_rd_data,

  output logic              sram_req,
  input  logic              sram_ready,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [1:0]        sram_be,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              sram_rd_data_vld,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              rd_err
);

  localparam int CW = $clog2(RD_DEPTH) + 1;
  localparam logic [CW-1:0] RD_MAX = CW'(RD_DEPTH);

  sram_cmd_t     cmd;
  logic          cmd_vld;
  sram_port_t    cmd_port;

  logic          issue;
  logic          rd_issue;
  logic          can_load;
  logic [CW-1:0] rd_cnt;
  logic          elig0;
  logic          elig1;
  sram_port_t    sel;
  logic          grant;

  logic          fifo_push;
  logic          fifo_pop;
  sram_port_t    fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  assign issue    = cmd_vld && sram_ready;
  assign rd_issue = issue && cmd.rd;
  assign can_load = !cmd_vld || sram_ready;

  // A read parked in the command register already holds a slot
  assign rd_cnt = fifo_count + CW'(cmd_vld && cmd.rd);
  assign elig0  = p0_req && (!p0_rd || (rd_cnt < RD_MAX));
  assign elig1  = p1_req && (!p1_rd || (rd_cnt < RD_MAX));

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Port 0 wins any contention
  always_comb begin
    sel = elig0 ? 1'b0 : 1'b1;
  end
`else
  sram_port_t last;

  // Under contention pick the port that was not granted last
  always_comb begin
    if (elig0 && elig1) sel = ~last;
    else                sel = elig0 ? 1'b0 : 1'b1;
  end

  // Remember the most recent grant; reset value lets port 0 win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last <= 1'b1;
    else if (grant) last <= sel;
  end
`endif

  assign grant    = can_load && (elig0 || elig1);
  assign p0_ready = grant && (sel == 1'b0);
  assign p1_ready = grant && (sel == 1'b1);

  // One-entry command register toward the controller; refills in the cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld  <= 1'b0;
      cmd      <= '0;
      cmd_port <= 1'b0;
    end else if (grant) begin
      cmd_vld  <= 1'b1;
      cmd_port <= sel;
      if (sel == 1'b0) cmd <= '{rd: p0_rd, addr: p0_addr, be: p0_be, wr_data: p0_wr_data};
      else             cmd <= '{rd: p1_rd, addr: p1_addr, be: p1_be, wr_data: p1_wr_data};
    end else if (issue) begin
      cmd_vld <= 1'b0;
    end
  end

  assign sram_req     = cmd_vld;
  assign sram_rd      = cmd.rd;
  assign sram_addr    = cmd.addr;
  assign sram_be      = cmd.be;
  assign sram_wr_data = cmd.wr_data;

  // rd_cnt keeps the FIFO from overflowing; the full term is a backstop only
  assign fifo_push = rd_issue && !fifo_full;
  assign fifo_pop  = sram_rd_data_vld && !fifo_empty;

  sram_arb_tagfifo #(
    .DEPTH (RD_DEPTH),
    .CW    (CW)
  ) u_tagfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (cmd_port),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign p0_rd_data_vld = fifo_pop && (fifo_head == 1'b0);
  assign p1_rd_data_vld = fifo_pop && (fifo_head == 1'b1);
  assign p0_rd_data     = sram_rd_data;
  assign p1_rd_data     = sram_rd_data;

  // Sticky flag for read data that nobody asked for
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 rd_err <= 1'b0;
    else if (sram_rd_data_vld && fifo_empty) rd_err <= 1'b1;
  end

endmodule
